// File: rtl/ssd_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller.
// Each digit slot starts with dead time, and loads are double-buffered so the display changes only at frame boundaries.
module ssd_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_data_in,
    input  logic [3:0]  i_dp_in,
    input  logic        i_load,
    input  logic        i_lz_en,
    input  logic        i_blank,
    output logic [7:0]  o_ssd,
    output logic [3:0]  o_an,
    output logic [1:0]  o_digit_idx,
    output logic        o_frame_tick
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b0100111;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    logic [CW-1:0] r_slot_cnt;
    logic [1:0]    r_dig;
    phase_t        r_phase;
    logic [15:0]   r_disp_data;
    logic [3:0]    r_disp_dp;
    logic [15:0]   r_pend_data;
    logic [3:0]    r_pend_dp;
    logic          r_pend;
    logic [3:0]    r_an;
    logic [7:0]    r_ssd;
    logic          r_frame_tick;

    logic          w_slot_end;
    logic [CW-1:0] w_slot_nxt;
    logic [3:0]    w_nib;
    logic          w_lz_sup;

    // Slot counter advance and leading-zero detection for the digit being scanned.
    always_comb begin
        w_slot_end = (r_slot_cnt == SLOT_LAST);
        if (w_slot_end) begin
            w_slot_nxt = '0;
        end else begin
            w_slot_nxt = r_slot_cnt + CW'(1);
        end
        w_nib    = r_disp_data[{r_dig, 2'b00} +: 4];
        w_lz_sup = 1'b0;
        if (i_lz_en) begin
            case (r_dig)
                2'd3:    w_lz_sup = (r_disp_data[15:12] == 4'h0);
                2'd2:    w_lz_sup = (r_disp_data[15:8] == 8'h00);
                2'd1:    w_lz_sup = (r_disp_data[15:4] == 12'h000);
                default: w_lz_sup = 1'b0;
            endcase
        end else begin
            w_lz_sup = 1'b0;
        end
    end

    // Scan FSM; outputs reflect the state held before each edge, giving one cycle of latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot_cnt   <= '0;
            r_dig        <= 2'd0;
            r_phase      <= PH_BLANK;
            r_an         <= 4'hF;
            r_ssd        <= 8'hFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_slot_cnt   <= w_slot_nxt;
            if (w_slot_end) begin
                r_dig <= r_dig + 2'd1;
            end
            r_phase      <= (w_slot_nxt < BLANK_END) ? PH_BLANK : PH_DRIVE;
            r_frame_tick <= w_slot_end && (r_dig == 2'd3);
            if (i_blank || (r_phase == PH_BLANK)) begin
                r_an  <= 4'hF;
                r_ssd <= 8'hFF;
            end else begin
                r_an  <= ~(4'b0001 << r_dig);
                r_ssd <= {~r_disp_dp[r_dig], w_lz_sup ? 7'h7F : seg_decode(w_nib)};
            end
        end
    end

    // Double buffer: a load coinciding with the frame tick bypasses the pending register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_disp_data <= 16'h0000;
            r_disp_dp   <= 4'h0;
            r_pend_data <= 16'h0000;
            r_pend_dp   <= 4'h0;
            r_pend      <= 1'b0;
        end else if (r_frame_tick) begin
            if (i_load) begin
                r_disp_data <= i_data_in;
                r_disp_dp   <= i_dp_in;
            end else if (r_pend) begin
                r_disp_data <= r_pend_data;
                r_disp_dp   <= r_pend_dp;
            end
            r_pend <= 1'b0;
        end else if (i_load) begin
            r_pend_data <= i_data_in;
            r_pend_dp   <= i_dp_in;
            r_pend      <= 1'b1;
        end
    end

    assign o_an         = r_an;
    assign o_ssd        = r_ssd;
    assign o_frame_tick = r_frame_tick;
    assign o_digit_idx  = r_dig;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl with REFRESH_DIV=8, BLANK_CYC=2.
// Loads are queued and retired at frame boundaries; every cycle is compared against a position-based model.
module tb_ssd_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] i_data_in;
    logic [3:0]  i_dp_in;
    logic        i_load;
    logic        i_lz_en;
    logic        i_blank;
    logic [7:0]  o_ssd;
    logic [3:0]  o_an;
    logic [1:0]  o_digit_idx;
    logic        o_frame_tick;

    ssd_scan_ctrl #(
        .REFRESH_DIV (8),
        .BLANK_CYC   (2)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_data_in    (i_data_in),
        .i_dp_in      (i_dp_in),
        .i_load       (i_load),
        .i_lz_en      (i_lz_en),
        .i_blank      (i_blank),
        .o_ssd        (o_ssd),
        .o_an         (o_an),
        .o_digit_idx  (o_digit_idx),
        .o_frame_tick (o_frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
    } ld_t;

    ld_t         ld_q[$];
    logic [6:0]  seg_tbl [16];
    logic [15:0] exp_data;
    logic [3:0]  exp_dp;
    int          pos;
    int          total;
    int          passed;
    int          fails;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        total++;
        assert (got === want) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h (pos %0d)", tag, got, want, pos);
        end
    endtask

    function automatic logic [7:0] exp_seg(input int d);
        logic [3:0]  nib;
        logic [15:0] upper;
        logic        sup;
        nib   = exp_data[d*4 +: 4];
        upper = exp_data >> (d * 4);
        sup   = i_lz_en && (d > 0) && (upper == 16'h0000);
        return {~exp_dp[d], sup ? 7'h7F : seg_tbl[nib]};
    endfunction

    task automatic step();
        ld_t        e;
        int         cnt;
        int         dig;
        logic [3:0] ean;
        logic [7:0] essd;
        @(negedge clk);
        pos++;
        if (pos % 32 == 0) begin
            while (ld_q.size() > 0) begin
                e        = ld_q.pop_front();
                exp_data = e.data;
                exp_dp   = e.dp;
            end
        end
        cnt = pos % 8;
        dig = (pos / 8) % 4;
        if (i_blank || cnt < 2) begin
            ean  = 4'hF;
            essd = 8'hFF;
        end else begin
            ean  = ~(4'b0001 << dig);
            essd = exp_seg(dig);
        end
        chk("an", {4'h0, o_an}, {4'h0, ean});
        chk("ssd", o_ssd, essd);
        chk("frame_tick", {7'h00, o_frame_tick}, (pos % 32 == 31) ? 8'h01 : 8'h00);
        chk("digit_idx", {6'h00, o_digit_idx}, 8'(((pos + 1) / 8) % 4));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic run_to(input int m);
        for (int k = 0; k < 64 && (pos % 32) != m; k++) step();
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p);
        ld_t e;
        e.data    = d;
        e.dp      = p;
        i_data_in = d;
        i_dp_in   = p;
        i_load    = 1'b1;
        ld_q.push_back(e);
        step();
        i_load    = 1'b0;
    endtask

    initial begin
        seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110};
        total = 0; passed = 0; fails = 0;
        rst_n = 1'b0; i_data_in = 16'h0000; i_dp_in = 4'h0;
        i_load = 1'b0; i_lz_en = 1'b0; i_blank = 1'b0;
        exp_data = 16'h0000; exp_dp = 4'h0; pos = -1;

        repeat (2) @(negedge clk);
        chk("rst_an", {4'h0, o_an}, 8'h0F);
        chk("rst_ssd", o_ssd, 8'hFF);
        chk("rst_ft", {7'h00, o_frame_tick}, 8'h00);
        chk("rst_idx", {6'h00, o_digit_idx}, 8'h00);
        rst_n = 1'b1;
        pos   = -1;

        // free run: blank zeros on every digit, first tick at pos 31
        run(32);
        run(5);
        load(16'h1234, 4'b0001);
        run_to(26);
        chk("old_d3", o_ssd, 8'hC0);
        run_to(2);
        chk("l1234_d0", o_ssd, 8'h19);
        chk("l1234_an0", {4'h0, o_an}, 8'h0E);
        run_to(10);
        chk("l1234_d1", o_ssd, 8'hB0);
        run_to(18);
        chk("l1234_d2", o_ssd, 8'hA4);
        run_to(26);
        chk("l1234_d3", o_ssd, 8'hF9);

        // leading-zero suppression
        i_lz_en = 1'b1;
        load(16'h0045, 4'b0000);
        run_to(2);
        chk("lz45_d0", o_ssd, 8'h92);
        run_to(10);
        chk("lz45_d1", o_ssd, 8'h99);
        run_to(18);
        chk("lz45_d2", o_ssd, 8'hFF);
        run_to(26);
        chk("lz45_d3", o_ssd, 8'hFF);
        load(16'h0000, 4'b0000);
        run_to(2);
        chk("lz0_d0", o_ssd, 8'hC0);
        run_to(10);
        chk("lz0_d1", o_ssd, 8'hFF);
        i_lz_en = 1'b0;

        // two loads in one frame: latest wins
        run_to(12);
        load(16'hAAAA, 4'b0000);
        run(3);
        load(16'h5555, 4'b0000);
        run_to(2);
        chk("latest_d0", o_ssd, 8'h92);

        // load in the frame-tick cycle goes straight to the display
        run_to(31);
        chk("ft_seen", {7'h00, o_frame_tick}, 8'h01);
        load(16'hBEEF, 4'b0000);
        run_to(2);
        chk("beef_d0", o_ssd, 8'h8E);
        run_to(10);
        chk("beef_d1", o_ssd, 8'h86);
        run_to(26);
        chk("beef_d3", o_ssd, 8'h83);

        // blank pulse during DRIVE
        run_to(10);
        i_blank = 1'b1;
        step();
        chk("blank_an", {4'h0, o_an}, 8'h0F);
        run(4);
        i_blank = 1'b0;
        run_to(31);
        chk("blank_ft", {7'h00, o_frame_tick}, 8'h01);

        // asynchronous reset mid-DRIVE on digit 2
        run_to(21);
        rst_n = 1'b0;
        #1;
        chk("arst_an", {4'h0, o_an}, 8'h0F);
        chk("arst_ssd", o_ssd, 8'hFF);
        chk("arst_ft", {7'h00, o_frame_tick}, 8'h00);
        chk("arst_idx", {6'h00, o_digit_idx}, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pos = -1;
        exp_data = 16'h0000;
        exp_dp = 4'h0;
        ld_q.delete();
        run(2);
        chk("post_rst_blank", {4'h0, o_an}, 8'h0F);
        step();
        chk("post_rst_d0", o_ssd, 8'hC0);
        chk("post_rst_an0", {4'h0, o_an}, 8'h0E);
        run(32);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
